hs_to_sync: RTL

Clocked receiver that terminates the 4-phase bundled-data channel leaving the arbiter/merge stage and converts it into a synchronous valid/ready stream. It synchronises the incoming request into the `clk` domain and acknowledges each word only after it has been written into a small internal FIFO. The downstream synchronous logic drains words at its own pace. It is the boundary between the clockless arbitration fabric and the clocked datapath.

---
 rtl/hs_pkg.sv | 18 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/hs_to_sync.sv | 88 ++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared types and width helpers for the 4-phase to valid/ready receiver.
package hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with an explicit occupancy counter; full/empty are
// derived from the registered level so they reflect the state before any pop.
module sync_fifo
  import hs_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  logic [N-1:0]                wd,
  output logic                        full,
  input  logic                        rd,
  output logic [N-1:0]                rdata,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_level == FULL_LEVEL);
  assign empty  = (r_level == '0);
  assign w_push = wr && !full;
  assign w_pop  = rd && !empty;
  assign rdata  = r_mem[r_rd_ptr];
  assign level  = r_level;

  // Storage is cleared on reset so the head reads as zero until first write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/hs_to_sync.sv
// Terminates a 4-phase bundled-data channel: synchronises the request, writes
// each word once into a FIFO, and acknowledges only after the write.
module hs_to_sync
  import hs_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        r_i,
  output logic                        a_i,
  input  logic [N-1:0]                d_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [N-1:0]                d_o,
  output logic [level_w(DEPTH)-1:0]   level_o
);

  logic [SYNC-1:0] r_sync;
  hs_state_t       r_state;
  logic            r_ack;
  logic            w_r_s;
  logic            w_full;
  logic            w_empty;
  logic            w_wr;
  logic            w_rd;

  // Only the request crosses domains; d_i is trusted once r_s is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], r_i};
    end
  end

  assign w_r_s = r_sync[SYNC-1];
  assign w_wr  = (r_state == IDLE) && w_r_s && !w_full;
  assign w_rd  = valid_o && ready_i;

  // A full FIFO simply leaves us in IDLE with ack low, which stalls upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_r_s && !w_full) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
          end
        end
        ACK: begin
          if (!w_r_s) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign a_i     = r_ack;
  assign valid_o = !w_empty;

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (w_wr),
    .wd    (d_i),
    .full  (w_full),
    .rd    (w_rd),
    .rdata (d_o),
    .empty (w_empty),
    .level (level_o)
  );

endmodule
